iob_native2axi: RTL

Single-outstanding bridge from the IOb native request/response interface to an AXI4 master port, issuing one single-beat (len 0) INCR transaction per native request. It sits directly upstream of iob_axi_ram (or any AXI4 slave), letting native-bus cores use AXI memories. Only one transaction is in flight at a time.

---
 rtl/iob_native2axi.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/iob_native2axi.sv
// Bridge from the IOb native request/response bus to an AXI4 master port.
// One single-beat INCR transaction in flight at a time; all outputs registered.
module iob_native2axi #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned AXI_ID = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  iob_valid_i,
  input  logic [ADDR_W-1:0]     iob_addr_i,
  input  logic [DATA_W-1:0]     iob_wdata_i,
  input  logic [DATA_W/8-1:0]   iob_wstrb_i,
  output logic                  iob_ready_o,
  output logic                  iob_rvalid_o,
  output logic [DATA_W-1:0]     iob_rdata_o,
  output logic                  err_o,
  output logic [ID_W-1:0]       axi_awid_o,
  output logic [ADDR_W-1:0]     axi_awaddr_o,
  output logic [LEN_W-1:0]      axi_awlen_o,
  output logic [2:0]            axi_awsize_o,
  output logic [1:0]            axi_awburst_o,
  output logic [1:0]            axi_awlock_o,
  output logic [3:0]            axi_awcache_o,
  output logic [2:0]            axi_awprot_o,
  output logic [3:0]            axi_awqos_o,
  output logic                  axi_awvalid_o,
  input  logic                  axi_awready_i,
  output logic [DATA_W-1:0]     axi_wdata_o,
  output logic [DATA_W/8-1:0]   axi_wstrb_o,
  output logic                  axi_wlast_o,
  output logic                  axi_wvalid_o,
  input  logic                  axi_wready_i,
  input  logic [ID_W-1:0]       axi_bid_i,
  input  logic [1:0]            axi_bresp_i,
  input  logic                  axi_bvalid_i,
  output logic                  axi_bready_o,
  output logic [ID_W-1:0]       axi_arid_o,
  output logic [ADDR_W-1:0]     axi_araddr_o,
  output logic [LEN_W-1:0]      axi_arlen_o,
  output logic [2:0]            axi_arsize_o,
  output logic [1:0]            axi_arburst_o,
  output logic [1:0]            axi_arlock_o,
  output logic [3:0]            axi_arcache_o,
  output logic [2:0]            axi_arprot_o,
  output logic [3:0]            axi_arqos_o,
  output logic                  axi_arvalid_o,
  input  logic                  axi_arready_i,
  input  logic [ID_W-1:0]       axi_rid_i,
  input  logic [DATA_W-1:0]     axi_rdata_i,
  input  logic [1:0]            axi_rresp_i,
  input  logic                  axi_rlast_i,
  input  logic                  axi_rvalid_i,
  output logic                  axi_rready_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SIZE   = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // Response IDs and rlast carry no information for a single-beat, single-ID master.
  logic unused_inputs;
  assign unused_inputs = ^{axi_bid_i, axi_rid_i, axi_rlast_i};

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (iob_valid_i && ready_q) begin
          ready_d = 1'b0;
          addr_d  = iob_addr_i;
          wdata_d = iob_wdata_i;
          wstrb_d = iob_wstrb_i;
          if (|iob_wstrb_i) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = READ;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // AW and W complete independently, in either order.
        awvalid_d = awvalid_q && !axi_awready_i;
        wvalid_d  = wvalid_q && !axi_wready_i;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: begin
        if (axi_bvalid_i) begin
          state_d  = IDLE;
          bready_d = 1'b0;
          ready_d  = 1'b1;
          err_d    = |axi_bresp_i;
        end
      end
      READ: begin
        if (arvalid_q && axi_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
        if (rready_q && axi_rvalid_i) begin
          state_d  = IDLE;
          rready_d = 1'b0;
          ready_d  = 1'b1;
          rvalid_d = 1'b1;
          err_d    = |axi_rresp_i;
          rdata_d  = axi_rdata_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
    end
  end

  assign iob_ready_o   = ready_q;
  assign iob_rvalid_o  = rvalid_q;
  assign iob_rdata_o   = rdata_q;
  assign err_o         = err_q;

  assign axi_awid_o    = ID_W'(AXI_ID);
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = '0;
  assign axi_awsize_o  = 3'(SIZE);
  assign axi_awburst_o = 2'b01;
  assign axi_awlock_o  = 2'b00;
  assign axi_awcache_o = 4'b0011;
  assign axi_awprot_o  = 3'b000;
  assign axi_awqos_o   = 4'b0000;
  assign axi_awvalid_o = awvalid_q;

  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = wstrb_q;
  assign axi_wlast_o   = 1'b1;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_bready_o  = bready_q;

  assign axi_arid_o    = ID_W'(AXI_ID);
  assign axi_araddr_o  = addr_q;
  assign axi_arlen_o   = '0;
  assign axi_arsize_o  = 3'(SIZE);
  assign axi_arburst_o = 2'b01;
  assign axi_arlock_o  = 2'b00;
  assign axi_arcache_o = 4'b0011;
  assign axi_arprot_o  = 3'b000;
  assign axi_arqos_o   = 4'b0000;
  assign axi_arvalid_o = arvalid_q;
  assign axi_rready_o  = rready_q;

endmodule
